// File: rtl/idelay_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// idelay_tap_ctrl_if
//
// Command bus between the calibration logic (master) and the IDELAY tap
// sequencer (slave). The calibration side posts one tap command at a time and
// watches for the completion pulse, the sticky readback error and the tap
// value the sequencer believes the delay line currently holds.
//
// Signals:
//   cmdValid   master -> slave  command request, held until accepted
//   cmdReady   slave -> master  sequencer is idle and will take a command
//   cmdOp      master -> slave  00 LOAD, 01 INC, 10 DEC, 11 reserved (no-op)
//   cmdArg     master -> slave  LOAD value, or step count for INC/DEC
//   done       slave -> master  one-cycle pulse when a command has finished
//   err        slave -> master  sticky readback mismatch
//   tapShadow  slave -> master  tap value the sequencer expects in the line
// ---------------------------------------------------------------------------
interface idelay_tap_ctrl_if #(
   parameter int TAP_W = 9
);

   logic             cmdValid;
   logic             cmdReady;
   logic [1:0]       cmdOp;
   logic [TAP_W-1:0] cmdArg;
   logic             done;
   logic             err;
   logic [TAP_W-1:0] tapShadow;

   // Calibration logic that issues tap commands
   modport master (
      output cmdValid,
      output cmdOp,
      output cmdArg,
      input  cmdReady,
      input  done,
      input  err,
      input  tapShadow
   );

   // Tap sequencer that executes them
   modport slave (
      input  cmdValid,
      input  cmdOp,
      input  cmdArg,
      output cmdReady,
      output done,
      output err,
      output tapShadow
   );

endinterface

// File: rtl/idelay_tap_ctrl.sv
// ---------------------------------------------------------------------------
// idelay_tap_ctrl
//
// Owns the control pins of one IDELAYE3 instance running in VAR_LOAD / COUNT
// mode and turns single tap commands (LOAD value, INC by N, DEC by N) into a
// legal pin sequence: EN_VTC is dropped, a settle time elapses, the LOAD or
// CE/INC pulses are issued with idle gaps between them, CNTVALUEOUT is
// optionally read back, and EN_VTC is restored with a one-cycle DONE pulse.
//
// Optional feature (compile-time macro IDELAY_TAP_CTRL_READBACK_EN):
//   defined   - after the last pulse the sequencer waits RB_WAIT cycles,
//               compares CNTVALUEOUT with its shadow tap value and raises a
//               sticky error on mismatch.
//   undefined - readback is skipped, err is tied low and dlyCntValueOut_i is
//               ignored; every command finishes RB_WAIT+1 cycles sooner.
//
// Ports:
//   clk_i              control clock, shared with the IDELAYE3 CLK
//   rstN_i             synchronous active-low reset
//   cmd                command bus (slave side of idelay_tap_ctrl_if)
//   dlyLoad_o          IDELAYE3 LOAD
//   dlyCe_o            IDELAYE3 CE
//   dlyInc_o           IDELAYE3 INC
//   dlyCntValueIn_o    IDELAYE3 CNTVALUEIN
//   dlyEnVtc_o         IDELAYE3 EN_VTC
//   dlyCntValueOut_i   IDELAYE3 CNTVALUEOUT
//
// Parameters:
//   TAP_W       tap/count width, max tap = 2^TAP_W-1
//   VTC_SETTLE  cycles EN_VTC is held low before the first control pulse
//   STEP_GAP    idle cycles after every CE or LOAD pulse
//   RB_WAIT     cycles between the last pulse and the CNTVALUEOUT sample
// ---------------------------------------------------------------------------
module idelay_tap_ctrl #(
   parameter int TAP_W      = 9,
   parameter int VTC_SETTLE = 8,
   parameter int STEP_GAP   = 2,
   parameter int RB_WAIT    = 3
) (
   input  logic             clk_i,
   input  logic             rstN_i,
   idelay_tap_ctrl_if.slave cmd,
   output logic             dlyLoad_o,
   output logic             dlyCe_o,
   output logic             dlyInc_o,
   output logic [TAP_W-1:0] dlyCntValueIn_o,
   output logic             dlyEnVtc_o,
   input  logic [TAP_W-1:0] dlyCntValueOut_i
);

   // One shared down-counter serves the settle wait, the inter-pulse gap and
   // the readback wait, so it is sized for the largest of the three.
   localparam int CNT_MAX_A = (VTC_SETTLE > STEP_GAP) ? VTC_SETTLE : STEP_GAP;
   localparam int CNT_MAX   = (CNT_MAX_A > RB_WAIT) ? CNT_MAX_A : RB_WAIT;
   localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [TAP_W-1:0] TAP_MAX = '1;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_NOP  = 2'b11
   } op_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_VTC_OFF,
      S_WAIT_VTC,
      S_LOAD,
      S_STEP,
      S_GAP,
      S_CHECK,
      S_VTC_ON
   } state_t;

   state_t           state_q;
   op_t              op_q;
   logic [TAP_W-1:0] arg_q;
   logic [TAP_W-1:0] remain_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TAP_W-1:0] shadow_q;
   logic             ready_q;
   logic             done_q;
   logic             load_q;
   logic             ce_q;
   logic             inc_q;
   logic [TAP_W-1:0] cntIn_q;
   logic             enVtc_q;

   logic [TAP_W-1:0] headroom;
   logic [TAP_W-1:0] remain_d;
   logic             waitDone;
   logic             gapDone;
   logic             startLoad;
   logic             startStep;
   logic             finishSteps;

   // The step count is clipped against the shadow tap at acceptance time so
   // the delay line can never be walked past either end. LOAD and the
   // reserved op carry no steps at all.
   always_comb begin
      headroom = TAP_MAX - shadow_q;
      remain_d = '0;
      case (cmd.cmdOp)
         OP_INC:  remain_d = (cmd.cmdArg > headroom) ? headroom : cmd.cmdArg;
         OP_DEC:  remain_d = (cmd.cmdArg > shadow_q) ? shadow_q : cmd.cmdArg;
         default: remain_d = '0;
      endcase
   end

   // Decisions shared by several states: the end of the settle wait and the
   // end of an inter-pulse gap both lead either to another pulse or to the
   // wrap-up. With STEP_GAP of zero the pulse state itself ends the gap.
   always_comb begin
      waitDone    = (state_q == S_WAIT_VTC) && (cnt_q == '0);
      gapDone     = ((state_q == S_GAP) && (cnt_q == '0)) ||
                    (((state_q == S_LOAD) || (state_q == S_STEP)) && (STEP_GAP == 0));
      startLoad   = waitDone && (op_q == OP_LOAD);
      startStep   = ((waitDone && (op_q != OP_LOAD)) || gapDone) && (remain_q != '0);
      finishSteps = ((waitDone && (op_q != OP_LOAD)) || gapDone) && (remain_q == '0);
   end

`ifdef IDELAY_TAP_CTRL_READBACK_EN
   logic err_q;
`endif

   // Main sequencer. All pin outputs are registered and change on the same
   // edge that enters the state they belong to, so a pulse lasts exactly the
   // one cycle spent in LOAD or STEP. The pulse / wrap-up transitions are
   // applied after the per-state case so they take precedence over it.
   always_ff @(posedge clk_i) begin
      if (!rstN_i) begin
         state_q  <= S_IDLE;
         op_q     <= OP_NOP;
         arg_q    <= '0;
         remain_q <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         load_q   <= 1'b0;
         ce_q     <= 1'b0;
         inc_q    <= 1'b0;
         cntIn_q  <= '0;
         enVtc_q  <= 1'b1;
`ifdef IDELAY_TAP_CTRL_READBACK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         load_q <= 1'b0;
         ce_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (cmd.cmdValid) begin
                  op_q     <= op_t'(cmd.cmdOp);
                  arg_q    <= cmd.cmdArg;
                  remain_q <= remain_d;
                  ready_q  <= 1'b0;
                  enVtc_q  <= 1'b0;
`ifdef IDELAY_TAP_CTRL_READBACK_EN
                  err_q    <= 1'b0;
`endif
                  state_q  <= S_VTC_OFF;
               end
            end

            S_VTC_OFF: begin
               cnt_q   <= CNT_W'(VTC_SETTLE);
               state_q <= S_WAIT_VTC;
            end

            S_WAIT_VTC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_LOAD, S_STEP: begin
               if (STEP_GAP != 0) begin
                  cnt_q   <= CNT_W'(STEP_GAP - 1);
                  state_q <= S_GAP;
               end
            end

            S_GAP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

`ifdef IDELAY_TAP_CTRL_READBACK_EN
            S_CHECK: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  if (dlyCntValueOut_i != shadow_q) begin
                     err_q <= 1'b1;
                  end
                  enVtc_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_VTC_ON;
               end
            end
`endif

            S_VTC_ON: begin
               ready_q <= 1'b1;
               inc_q   <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (startLoad) begin
            load_q   <= 1'b1;
            ce_q     <= 1'b1;
            inc_q    <= 1'b0;
            cntIn_q  <= arg_q;
            shadow_q <= arg_q;
            state_q  <= S_LOAD;
         end

         if (startStep) begin
            ce_q     <= 1'b1;
            inc_q    <= (op_q == OP_INC);
            shadow_q <= (op_q == OP_INC) ? shadow_q + 1'b1 : shadow_q - 1'b1;
            remain_q <= remain_q - 1'b1;
            state_q  <= S_STEP;
         end

         if (finishSteps) begin
`ifdef IDELAY_TAP_CTRL_READBACK_EN
            cnt_q   <= CNT_W'(RB_WAIT);
            state_q <= S_CHECK;
`else
            enVtc_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_VTC_ON;
`endif
         end
      end
   end

   // Without readback the delay line's count output has no consumer.
`ifdef IDELAY_TAP_CTRL_READBACK_EN
   assign cmd.err = err_q;
`else
   logic unusedCntOut;
   assign unusedCntOut = ^dlyCntValueOut_i;
   assign cmd.err      = 1'b0;
`endif

   // Output wiring; every value below is a register.
   assign cmd.cmdReady    = ready_q;
   assign cmd.done        = done_q;
   assign cmd.tapShadow   = shadow_q;
   assign dlyLoad_o       = load_q;
   assign dlyCe_o         = ce_q;
   assign dlyInc_o        = inc_q;
   assign dlyCntValueIn_o = cntIn_q;
   assign dlyEnVtc_o      = enVtc_q;

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_idelay_tap_ctrl
//
// Drives idelay_tap_ctrl with directed and random tap commands, emulates the
// IDELAYE3 tap counter behind it, and checks every output on every cycle
// against a timeline model: for each accepted command the model knows the
// clipped step count, the cycle offsets of its pulses, the DONE cycle and
// the tap value at every offset. A few literal expectations pin the model.
// Readback checks follow IDELAY_TAP_CTRL_READBACK_EN.
// ---------------------------------------------------------------------------
module tb_idelay_tap_ctrl;

   localparam int TAP_W      = 9;
   localparam int VTC_SETTLE = 8;
   localparam int STEP_GAP   = 2;
   localparam int RB_WAIT    = 3;
   localparam int TAP_MAX_I  = (1 << TAP_W) - 1;
   localparam logic [TAP_W-1:0] TAP_MAX = '1;

`ifdef IDELAY_TAP_CTRL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam int RBX   = RB ? RB_WAIT + 1 : 0;
   localparam int FIRST = 2 + VTC_SETTLE;
   localparam int PER   = 1 + STEP_GAP;

   // Hand-computed latencies (acceptance edge to DONE) for the directed cases
   localparam int LAT_LOAD  = RB ? 17 : 13;
   localparam int LAT_INC10 = RB ? 44 : 40;
   localparam int LAT_INC11 = RB ? 47 : 43;
   localparam int LAT_DEC3  = RB ? 23 : 19;
   localparam int LAT_NOP   = RB ? 14 : 10;
   localparam int HOLD_GAP  = RB ? 25 : 21;
   localparam int ERR_FORCE = RB ? 1 : 0;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             dlyLoad;
   logic             dlyCe;
   logic             dlyInc;
   logic             dlyEnVtc;
   logic [TAP_W-1:0] dlyCntIn;
   logic [TAP_W-1:0] dlyCntOut;

   idelay_tap_ctrl_if #(.TAP_W(TAP_W)) cmdIf ();

   idelay_tap_ctrl #(
      .TAP_W(TAP_W),
      .VTC_SETTLE(VTC_SETTLE),
      .STEP_GAP(STEP_GAP),
      .RB_WAIT(RB_WAIT)
   ) dut (
      .clk_i(clk),
      .rstN_i(rstN),
      .cmd(cmdIf.slave),
      .dlyLoad_o(dlyLoad),
      .dlyCe_o(dlyCe),
      .dlyInc_o(dlyInc),
      .dlyCntValueIn_o(dlyCntIn),
      .dlyEnVtc_o(dlyEnVtc),
      .dlyCntValueOut_i(dlyCntOut)
   );

   always #5 clk = ~clk;

   // Emulated delay-line tap counter, with an override for readback faults
   logic [TAP_W-1:0] lineTap = '0;
   logic             forceOut = 1'b0;
   logic [TAP_W-1:0] forceVal = '0;

   always @(posedge clk) begin
      if (dlyLoad === 1'b1) begin
         lineTap <= dlyCntIn;
      end else if (dlyCe === 1'b1) begin
         if (dlyInc === 1'b1) begin
            if (lineTap != TAP_MAX) lineTap <= lineTap + 1'b1;
         end else begin
            if (lineTap != '0) lineTap <= lineTap - 1'b1;
         end
      end
   end

   assign dlyCntOut = forceOut ? forceVal : lineTap;

   int nCompared = 0;
   int nMismatch = 0;
   int cyc = 0;
   bit checkEn = 1'b0;

   // Model state
   bit       mBusy = 1'b0;
   bit       mErr = 1'b0;
   bit       mJustReset = 1'b0;
   int       mOff = 0;
   int       mL = 0;
   int       mN = 0;
   int       mOp = 0;
   int       mArg = 0;
   int       mS0 = 0;
   int       mFinal = 0;
   int       mShadow = 0;
   int       accCyc = 0;
   int       accCount = 0;
   int       ceCount = 0;
   int       lastLat = -1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic timeoutFail(input string what);
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL timeout %s: bound expired (cycle %0d)", what, cyc);
   endtask

   // Model update at each edge, then a full output comparison 1 ns later
   always @(posedge clk) begin
      int  rel, k, eShadow;
      bit  ePulse, eReady, eDone, eEn;
      cyc++;
      mJustReset = 1'b0;
      if (!rstN) begin
         mBusy = 1'b0;
         mShadow = 0;
         mErr = 1'b0;
         mJustReset = 1'b1;
      end else if (!mBusy) begin
         if (cmdIf.cmdValid === 1'b1) begin
            mOp  = int'(cmdIf.cmdOp);
            mArg = int'(cmdIf.cmdArg);
            mS0  = mShadow;
            case (mOp)
               0: begin mN = 1; mFinal = mArg; end
               1: begin mN = (mArg < TAP_MAX_I - mS0) ? mArg : TAP_MAX_I - mS0; mFinal = mS0 + mN; end
               2: begin mN = (mArg < mS0) ? mArg : mS0; mFinal = mS0 - mN; end
               default: begin mN = 0; mFinal = mS0; end
            endcase
            mL = FIRST + mN * PER + RBX;
            mOff = 0;
            mBusy = 1'b1;
            mErr = 1'b0;
            accCyc = cyc;
            accCount++;
            ceCount = 0;
         end
      end else if (mOff == mL) begin
         mBusy = 1'b0;
         mShadow = mFinal;
      end else begin
         mOff++;
         if (mOff == mL && RB) mErr = (int'(dlyCntOut) != mFinal);
      end

      #1;
      if (dlyCe === 1'b1) ceCount++;
      if (cmdIf.done === 1'b1) lastLat = cyc - accCyc;

      if (checkEn) begin
         eReady = !mBusy;
         eDone  = mBusy && (mOff == mL);
         eEn    = !mBusy || (mOff == mL);
         ePulse = 1'b0;
         eShadow = mShadow;
         if (mBusy) begin
            k = 0;
            if (mOff >= FIRST && mOff < mL) begin
               rel = mOff - FIRST;
               ePulse = ((rel % PER) == 0) && ((rel / PER) < mN);
            end
            if (mOff >= FIRST) begin
               k = (mOff - FIRST) / PER + 1;
               if (k > mN) k = mN;
            end
            case (mOp)
               0: eShadow = (k > 0) ? mArg : mS0;
               1: eShadow = mS0 + k;
               2: eShadow = mS0 - k;
               default: eShadow = mS0;
            endcase
         end
         checkOutput("cmdReady", int'(cmdIf.cmdReady), int'(eReady));
         checkOutput("done", int'(cmdIf.done), int'(eDone));
         checkOutput("enVtc", int'(dlyEnVtc), int'(eEn));
         checkOutput("ce", int'(dlyCe), int'(ePulse));
         checkOutput("load", int'(dlyLoad), int'(ePulse && mOp == 0));
         checkOutput("tapShadow", int'(cmdIf.tapShadow), eShadow);
         checkOutput("err", int'(cmdIf.err), int'(mErr));
         if (ePulse && mOp != 0) checkOutput("inc", int'(dlyInc), int'(mOp == 1));
         if (ePulse && mOp == 0) checkOutput("cntValueIn", int'(dlyCntIn), mArg);
         if (mJustReset) begin
            checkOutput("rstInc", int'(dlyInc), 0);
            checkOutput("rstCntValueIn", int'(dlyCntIn), 0);
         end
      end
   end

   // Present a command at a falling edge and wait until it is taken
   task automatic applyStimulus(input logic [1:0] op, input int arg, input bit holdValid);
      int startAcc;
      int guard;
      startAcc = accCount;
      @(negedge clk);
      cmdIf.cmdOp    = op;
      cmdIf.cmdArg   = TAP_W'(arg);
      cmdIf.cmdValid = 1'b1;
      guard = 0;
      while (accCount == startAcc && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (accCount == startAcc) timeoutFail("accept");
      if (!holdValid) cmdIf.cmdValid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      while (mBusy && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (mBusy) timeoutFail("done");
      @(negedge clk);
   endtask

   initial begin
      int a1;
      int guard;
      cmdIf.cmdValid = 1'b0;
      cmdIf.cmdOp    = 2'b00;
      cmdIf.cmdArg   = '0;

      // Reset state
      @(negedge clk);
      checkEn = 1'b1;
      @(negedge clk);
      checkOutput("rstReady", int'(cmdIf.cmdReady), 1);
      checkOutput("rstEnVtc", int'(dlyEnVtc), 1);
      checkOutput("rstShadow", int'(cmdIf.tapShadow), 0);
      checkOutput("rstDone", int'(cmdIf.done), 0);
      rstN = 1'b1;

      // LOAD 50
      applyStimulus(2'b00, 50, 1'b0);
      waitIdle();
      checkOutput("t1Latency", lastLat, LAT_LOAD);
      checkOutput("t1Pulses", ceCount, 1);
      checkOutput("t1Shadow", int'(cmdIf.tapShadow), 50);
      checkOutput("t1Line", int'(lineTap), 50);
      checkOutput("t1Err", int'(cmdIf.err), 0);

      // INC 10 from 50
      applyStimulus(2'b01, 10, 1'b0);
      waitIdle();
      checkOutput("t2Latency", lastLat, LAT_INC10);
      checkOutput("t2Pulses", ceCount, 10);
      checkOutput("t2Shadow", int'(cmdIf.tapShadow), 60);
      checkOutput("t2EnVtc", int'(dlyEnVtc), 1);

      // DEC 5, then saturation at both ends
      applyStimulus(2'b10, 5, 1'b0);
      waitIdle();
      checkOutput("t3DecShadow", int'(cmdIf.tapShadow), 55);
      checkOutput("t3DecPulses", ceCount, 5);
      applyStimulus(2'b00, 500, 1'b0);
      waitIdle();
      applyStimulus(2'b01, 20, 1'b0);
      waitIdle();
      checkOutput("t3IncClipShadow", int'(cmdIf.tapShadow), 511);
      checkOutput("t3IncClipPulses", ceCount, 11);
      checkOutput("t3IncClipLatency", lastLat, LAT_INC11);
      applyStimulus(2'b00, 3, 1'b0);
      waitIdle();
      applyStimulus(2'b10, 100, 1'b0);
      waitIdle();
      checkOutput("t3DecClipShadow", int'(cmdIf.tapShadow), 0);
      checkOutput("t3DecClipPulses", ceCount, 3);
      checkOutput("t3DecClipLatency", lastLat, LAT_DEC3);

      // Readback fault: line reports 7 while 55 is expected
      forceOut = 1'b1;
      forceVal = 9'd7;
      applyStimulus(2'b00, 55, 1'b0);
      waitIdle();
      checkOutput("t4ErrSet", int'(cmdIf.err), ERR_FORCE);
      forceOut = 1'b0;
      applyStimulus(2'b01, 0, 1'b0);
      checkOutput("t4ErrCleared", int'(cmdIf.err), 0);
      waitIdle();

      // Reset during the 4th step of INC 10
      applyStimulus(2'b00, 40, 1'b0);
      waitIdle();
      applyStimulus(2'b01, 10, 1'b0);
      guard = 0;
      while (ceCount < 4 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (ceCount < 4) timeoutFail("fourthStep");
      rstN = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("t5EnVtc", int'(dlyEnVtc), 1);
      checkOutput("t5Ce", int'(dlyCe), 0);
      checkOutput("t5Ready", int'(cmdIf.cmdReady), 1);
      checkOutput("t5Shadow", int'(cmdIf.tapShadow), 0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(2'b00, 100, 1'b0);
      waitIdle();

      // Valid held through a busy command, followed by the reserved op
      applyStimulus(2'b01, 3, 1'b1);
      a1 = accCyc;
      @(negedge clk);
      cmdIf.cmdOp = 2'b11;
      applyStimulus(2'b11, 0, 1'b0);
      checkOutput("t6HoldGap", accCyc - a1, HOLD_GAP);
      waitIdle();
      checkOutput("t6NopPulses", ceCount, 0);
      checkOutput("t6NopLatency", lastLat, LAT_NOP);
      checkOutput("t6Shadow", int'(cmdIf.tapShadow), 103);

      // Random commands, occasional readback faults and mid-command resets
      for (int i = 0; i < 40; i++) begin
         int op;
         int arg;
         op  = $urandom_range(0, 3);
         arg = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TAP_MAX_I) : $urandom_range(0, 25);
         forceOut = ($urandom_range(0, 7) == 0);
         forceVal = TAP_W'($urandom_range(0, TAP_MAX_I));
         applyStimulus(2'(op), arg, 1'b0);
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rstN = 1'b0;
            @(negedge clk);
            rstN = 1'b1;
            forceOut = 1'b0;
            applyStimulus(2'b00, $urandom_range(0, TAP_MAX_I), 1'b0);
         end
         waitIdle();
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/idelay_tap_ctrl.md
Name: idelay_tap_ctrl

Overview:
Sequencer that owns the control pins of one IDELAYE3_asic instance (VAR_LOAD, COUNT format) and turns single tap commands into legal pin sequences. Each command is LOAD value, INC by N or DEC by N. For every command the block drops EN_VTC, waits a settle time, drives LOAD/CE/INC/CNTVALUEIN, optionally reads back CNTVALUEOUT, then restores EN_VTC. Sits between the calibration logic and the delay line.

Parameters:
TAP_W, 9, tap/count width; max tap = 2^TAP_W-1
VTC_SETTLE, 8, CLK cycles EN_VTC held low before the first control pulse
STEP_GAP, 2, idle CLK cycles after every CE or LOAD pulse
RB_WAIT, 3, CLK cycles between the last pulse and the CNTVALUEOUT sample

Ports:
CLK  in  1  control clock, shared with the IDELAYE3 CLK
RST_N  in  1  synchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE
CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 reserved (NOP)
CMD_ARG  in  TAP_W  LOAD value, or step count N for INC/DEC
DONE  out  1  one-cycle pulse on command completion
ERR  out  1  sticky readback mismatch; cleared by the next accepted command
TAP_SHADOW  out  TAP_W  expected tap value held by the controller
DLY_LOAD  out  1  to IDELAYE3 LOAD
DLY_CE  out  1  to IDELAYE3 CE
DLY_INC  out  1  to IDELAYE3 INC
DLY_CNTVALUEIN  out  TAP_W  to IDELAYE3 CNTVALUEIN
DLY_EN_VTC  out  1  to IDELAYE3 EN_VTC
DLY_CNTVALUEOUT  in  TAP_W  from IDELAYE3 CNTVALUEOUT

Behaviour:
- Single clock CLK, reset is synchronous and active-low (RST_N sampled on the CLK rising edge).
- Reset values:
  - State IDLE; CMD_READY=1; DONE=0; ERR=0.
  - TAP_SHADOW=0; DLY_LOAD=DLY_CE=DLY_INC=0; DLY_CNTVALUEIN=0; DLY_EN_VTC=1.
- Handshake: a command is accepted when CMD_VALID & CMD_READY. CMD_OP and CMD_ARG are registered on acceptance. CMD_READY drops the following cycle.
- States:
  - IDLE: accept a command, then go to VTC_OFF.
  - VTC_OFF: DLY_EN_VTC=0; load the settle counter with VTC_SETTLE; go to WAIT_VTC.
  - WAIT_VTC: count down to 0, then go to LOAD, STEP or CHECK depending on the op.
  - LOAD: one cycle with DLY_LOAD=1, DLY_CE=1 and DLY_CNTVALUEIN=arg. TAP_SHADOW<=arg. Then GAP.
  - STEP: one cycle with DLY_CE=1 and DLY_INC=(op==INC). TAP_SHADOW changes by ±1. Remaining count decrements. Then GAP.
  - GAP: STEP_GAP idle cycles. Go back to STEP if the remaining count is nonzero, else go to CHECK.
  - CHECK: wait RB_WAIT cycles, compare DLY_CNTVALUEOUT to TAP_SHADOW, set ERR on mismatch. Go to VTC_ON.
  - VTC_ON: DLY_EN_VTC=1, DONE=1 for one cycle. Return to IDLE.
- DLY_CE, DLY_LOAD and DLY_INC are registered, one pulse per STEP/LOAD state. DLY_INC holds its value through GAP.
- Saturation: INC is clipped to (2^TAP_W-1 − TAP_SHADOW) steps and DEC to TAP_SHADOW steps, computed at acceptance. No wrap past 511 or below 0.
- N=0, a fully clipped step count, or the reserved op: no CE pulses are issued, but the VTC_OFF/WAIT_VTC/CHECK/VTC_ON sequence and DONE still occur.
- Latency for INC by N (unclipped), from the acceptance edge to the DONE pulse: 2 + VTC_SETTLE + N·(1+STEP_GAP) + RB_WAIT + 1 cycles. LOAD is the same with N=1.
- CMD_VALID while busy is ignored; it is held by the requester.
- Reset mid-command returns all outputs to reset values next edge, including DLY_EN_VTC=1. TAP_SHADOW=0 after reset does not match the delay line, so the first command after reset must be a LOAD.

Optional Feature:
IDELAY_TAP_CTRL_READBACK_EN
- Defined: CHECK behaves as described and ERR is live.
- Undefined: CHECK is bypassed (GAP goes straight to VTC_ON), ERR is tied 0 and DLY_CNTVALUEOUT is unused. Latency is reduced by RB_WAIT+1 cycles.

Test Plan:
1. Reset, then LOAD 50 with defaults -> DLY_EN_VTC low for ≥8 cycles before a single DLY_LOAD/DLY_CE pulse with CNTVALUEIN=50; DONE fires; TAP_SHADOW=50; delay CNTVALUEOUT=50; ERR=0.
2. INC N=10 from 50 -> exactly 10 CE pulses with INC=1, each separated by 2 idle cycles; TAP_SHADOW=60; DONE at the computed latency; EN_VTC back to 1.
3. DEC N=5 from 60, then INC N=20 from 500 -> 55, then 511 with only 11 CE pulses; DEC N=100 from 3 -> 0 with 3 pulses; no wrap.
4. With READBACK_EN: force DLY_CNTVALUEOUT=7 while expecting 55 -> ERR=1 after DONE; the next accepted command clears ERR.
5. Assert RST_N=0 during the 4th STEP of INC N=10 -> next cycle IDLE, DLY_EN_VTC=1, CE=0, CMD_READY=1, TAP_SHADOW=0.
6. CMD_VALID held through a busy command, and op=11 -> second command is accepted only after DONE; op=11 produces no CE/LOAD pulse but still pulses DONE.
